// File: rtl/spi_cfg_sequencer_if.sv
// rtl/spi_cfg_sequencer_if.sv - host, boot-table and SPI master signals of the config sequencer
// The sequencer connects through master; the surrounding logic connects through slave.
interface spi_cfg_sequencer_if #(
   parameter int AW = 6
);
   logic          boot_start;
   logic          host_req;
   logic [1:0]    host_sel;
   logic [31:0]   host_data;
   logic          host_ack;
   logic [31:0]   host_rdata;
   logic [AW-1:0] tbl_addr;
   logic [31:0]   tbl_data;
   logic          spi_go;
   logic [1:0]    spi_sel;
   logic [31:0]   spi_data_o;
   logic [31:0]   spi_data_i;
   logic          spi_done;
   logic          sync;
   logic          busy;
   logic          boot_done;
   logic          err;

   modport master (
      input  boot_start, host_req, host_sel, host_data, tbl_data, spi_data_i, spi_done,
      output host_ack, host_rdata, tbl_addr, spi_go, spi_sel, spi_data_o, sync, busy,
             boot_done, err
   );

   modport slave (
      output boot_start, host_req, host_sel, host_data, tbl_data, spi_data_i, spi_done,
      input  host_ack, host_rdata, tbl_addr, spi_go, spi_sel, spi_data_o, sync, busy,
             boot_done, err
   );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// rtl/spi_cfg_sequencer.sv - boot-table and host SPI transfer sequencer for the clock chips
// Optional: define BOOT_ON_RESET_EN to launch the boot table automatically after reset.
module spi_cfg_sequencer #(
   parameter int NUM_SLAVES = 3,
   parameter int NUM_WORDS  = 16,
   parameter int SYNC_LEN   = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                clock,
   input  logic                rst_n,
   spi_cfg_sequencer_if.master bus
);
   localparam int AW = $clog2(NUM_SLAVES * NUM_WORDS);
   localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int YW = $clog2(SYNC_LEN + 1);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, SYNC_P} state_t;
   state_t state, state_nx;

   logic [AW-1:0] tbl_addr_q;
   logic [1:0]    slave_q;
   logic [1:0]    sel_q;
   logic [WW-1:0] word_q;
   logic [31:0]   data_q;
   logic [31:0]   host_rdata_q;
   logic [TW-1:0] tmo_cnt;
   logic [YW-1:0] sync_cnt;
   logic          host_mode;
   logic          fetch_ph;
   logic          wait_first;
   logic          host_ack_q;
   logic          boot_done_q;
   logic          err_q;
   logic          auto_start;
   logic          hold_host;
   logic          start;
   logic          host_go;
   logic          sel_ok;
   logic          last_word;
   logic          last_slave;
   logic          done_ok;
   logic          tmo_hit;
   logic          sync_end;

`ifdef BOOT_ON_RESET_EN
   logic [3:0] por_cnt;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         por_cnt <= 4'd0;
      else if (por_cnt != 4'd8)
         por_cnt <= por_cnt + 4'd1;
   end

   // Host requests stay pending until the power-on boot has been launched.
   assign auto_start = (por_cnt == 4'd7);
   assign hold_host  = (por_cnt != 4'd8);
`else
   assign auto_start = 1'b0;
   assign hold_host  = 1'b0;
`endif

   assign start      = bus.boot_start | auto_start;
   // An ack still showing means the requester has not yet dropped host_req.
   assign host_go    = bus.host_req & ~host_ack_q & ~hold_host;
   assign sel_ok     = int'(bus.host_sel) < NUM_SLAVES;
   assign last_word  = (word_q == WW'(NUM_WORDS - 1));
   assign last_slave = (slave_q == 2'(NUM_SLAVES - 1));
   assign done_ok    = bus.spi_done & ~wait_first;
   assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
   assign sync_end   = (sync_cnt == YW'(SYNC_LEN - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start)
               state_nx = FETCH;
            else if (host_go && sel_ok)
               state_nx = ISSUE;
         end
         FETCH: begin
            if (fetch_ph)
               state_nx = ISSUE;
         end
         ISSUE:
            state_nx = WAIT;
         WAIT: begin
            if (done_ok) begin
               if (host_mode)
                  state_nx = IDLE;
               else if (last_word && last_slave)
                  state_nx = SYNC_P;
               else
                  state_nx = FETCH;
            end else if (tmo_hit) begin
               state_nx = IDLE;
            end
         end
         SYNC_P: begin
            if (sync_end)
               state_nx = IDLE;
         end
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         tbl_addr_q   <= '0;
         slave_q      <= '0;
         sel_q        <= '0;
         word_q       <= '0;
         data_q       <= '0;
         host_rdata_q <= '0;
         tmo_cnt      <= '0;
         sync_cnt     <= '0;
         host_mode    <= 1'b0;
         fetch_ph     <= 1'b0;
         wait_first   <= 1'b0;
         host_ack_q   <= 1'b0;
         boot_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         host_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  boot_done_q <= 1'b0;
                  err_q       <= 1'b0;
                  slave_q     <= '0;
                  word_q      <= '0;
                  tbl_addr_q  <= '0;
                  host_mode   <= 1'b0;
                  fetch_ph    <= 1'b0;
               end else if (host_go) begin
                  if (sel_ok) begin
                     sel_q     <= bus.host_sel;
                     data_q    <= bus.host_data;
                     host_mode <= 1'b1;
                  end else begin
                     host_ack_q   <= 1'b1;
                     host_rdata_q <= '0;
                  end
               end
            end
            FETCH: begin
               // Table ROM is synchronous: the word appears one cycle after the address.
               fetch_ph <= ~fetch_ph;
               if (fetch_ph) begin
                  data_q <= bus.tbl_data;
                  sel_q  <= slave_q;
               end
            end
            ISSUE: begin
               tmo_cnt    <= '0;
               wait_first <= 1'b1;
            end
            WAIT: begin
               wait_first <= 1'b0;
               if (done_ok) begin
                  if (host_mode) begin
                     host_rdata_q <= bus.spi_data_i;
                     host_ack_q   <= 1'b1;
                  end else if (!last_word) begin
                     word_q     <= word_q + WW'(1);
                     tbl_addr_q <= tbl_addr_q + AW'(1);
                  end else if (!last_slave) begin
                     slave_q    <= slave_q + 2'd1;
                     word_q     <= '0;
                     tbl_addr_q <= tbl_addr_q + AW'(1);
                  end else begin
                     sync_cnt <= '0;
                  end
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
                  if (host_mode) begin
                     host_ack_q   <= 1'b1;
                     host_rdata_q <= 32'hFFFF_FFFF;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            SYNC_P: begin
               sync_cnt <= sync_cnt + YW'(1);
               if (sync_end)
                  boot_done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Strobes decode straight from the async-reset state so they drop with rst_n.
   assign bus.spi_go     = (state == ISSUE);
   assign bus.sync       = (state == SYNC_P);
   assign bus.busy       = (state != IDLE);
   assign bus.spi_sel    = sel_q;
   assign bus.spi_data_o = data_q;
   assign bus.tbl_addr   = tbl_addr_q;
   assign bus.host_ack   = host_ack_q;
   assign bus.host_rdata = host_rdata_q;
   assign bus.boot_done  = boot_done_q;
   assign bus.err        = err_q;
endmodule
